tile_sel_gen: RTL
=================

Name: tile_sel_gen

Overview:
Per-pixel tile classifier on the display pipeline. Converts the current hcount/vcount into a tile-map read, merges map contents with player sprite boxes, and emits the 3-bit tile-type select plus the 10-bit in-tile ROM address consumed by the ROM banks and the downstream RGB select mux. Delays the timing signals by its own latency so they stay aligned with the outputs.

Parameters:
TILE_BITS, 5, log2 of tile edge in pixels (32x32 tiles)
MAP_COLS, 32, tile columns in map
MAP_ROWS, 24, tile rows in map

Ports:
i_pclk  in  1  pixel clock
i_rst_n  in  1  asynchronous active-low reset
i_hcount  in  11  horizontal pixel counter
i_vcount  in  11  vertical pixel counter
i_hsync  in  1  horizontal sync
i_vsync  in  1  vertical sync
i_hblnk  in  1  horizontal blanking
i_vblnk  in  1  vertical blanking
o_map_addr  out  10  map RAM address, row*MAP_COLS+col
i_map_data  in  3  map RAM data, valid 1 cycle after o_map_addr
i_plr1_en  in  1  player 1 visible
i_plr1_x  in  11  player 1 top-left x, pixels
i_plr1_y  in  11  player 1 top-left y, pixels
i_plr2_en  in  1  player 2 visible
i_plr2_x  in  11  player 2 top-left x
i_plr2_y  in  11  player 2 top-left y
o_sel  out  3  tile type: 0 path, 1 obs1, 2 obs2, 3 bomb, 4 expl, 5 plr1, 6 plr2
o_rom_addr  out  10  {row offset[4:0], col offset[4:0]} within tile or sprite
o_in_area  out  1  pixel inside map area and not blanked
o_hcount, o_vcount  out  11 each  delayed counters
o_hsync, o_vsync, o_hblnk, o_vblnk  out  1 each  delayed timing

Behaviour:
- Clock and reset: one clock, i_pclk. i_rst_n is asynchronous and active-low. While it is low, all registered outputs and internal pipeline and latch registers clear to 0. This means o_sel=0, o_rom_addr=0, o_map_addr=0, o_in_area=0, all delayed timing=0, and latched player state=0 with enables=0.
- Position latch:
  - Player x/y/en inputs are sampled into shadow registers only on the rising edge of i_vblnk (registered i_vblnk=0, current=1).
  - The whole frame uses the latched values, so there is no tearing.
  - After reset, players stay invisible until the first vblank rising edge.
- Pipeline, fixed latency of 2 cycles from inputs to every output:
  - Stage 1:
    - col = hcount >> TILE_BITS, row = vcount >> TILE_BITS.
    - o_map_addr is registered with row*MAP_COLS+col when col < MAP_COLS and row < MAP_ROWS; otherwise it is 0.
    - Registers the pixel offsets, the in-area flag (in map, not hblnk, not vblnk), the timing signals, and the player hit flags with their offsets.
  - Player hit test: hit = en and x ≤ hcount < x+32 and y ≤ vcount < y+32.
    - The comparison is done in 12 bits so x+32 does not wrap.
    - Offset = (hcount−x)[4:0], (vcount−y)[4:0].
  - Stage 2: i_map_data is now valid. o_sel, o_rom_addr, o_in_area and the timing outputs are registered.
- Select priority, highest first:
  1. If not in area: o_sel=0 and o_rom_addr=0.
  2. plr1 hit: o_sel=5 with the plr1 offset.
  3. plr2 hit: o_sel=6 with the plr2 offset.
  4. Otherwise the map code with tile offsets {vcount[4:0], hcount[4:0]}.
- Map codes 5–7 are reserved and map to path (0).
- Both players overlapping the same pixel: plr1 wins.
- A vblank rising edge during a stage-1 compare only affects pixels entering after the latch cycle.
- Reset mid-frame: the outputs return to reset values immediately, and the pipeline refills 2 cycles after release.

Test Plan:
- Reset: assert i_rst_n=0 mid-line with nonzero inputs → all outputs 0 asynchronously. Release → valid outputs 2 cycles after the first new inputs.
- Map lookup: hcount=70, vcount=40 → o_map_addr=1*32+2=34 one cycle later. Return i_map_data=2 → o_sel=2, o_rom_addr={5'd8,5'd6}, o_in_area=1, with the 2-cycle latency check on o_hcount=70.
- Reserved code and out of area: i_map_data=6 → o_sel=0. vcount=770 or hblnk=1 → o_sel=0, o_rom_addr=0, o_in_area=0.
- Player latch: set plr1 en=1, x=100, y=200 mid-frame → pixel (110,205) still shows the map type. After the vblank rising edge, next frame → o_sel=5, o_rom_addr={5'd5,5'd10}. Pixel (132,205) → map type.
- Overlap: plr1 at (100,200) and plr2 at (110,200) both enabled, pixel (115,210) → o_sel=5. Pixel (135,210) → o_sel=6, o_rom_addr={5'd10,5'd25}.
- Edge: plr2 x=1016, pixel hcount=1023 → hit, col offset 7. There is no wrap, so hcount=0 is not a hit.

Source files
------------

// File: rtl/tile_sel_gen.sv
// -----------------------------------------------------------------------------
// tile_sel_gen
//
// Per-pixel tile classifier for the display pipeline. The current pixel
// position is turned into a tile-map read. The map contents are then merged
// with the two player sprite boxes, and the block produces the tile-type
// select plus the in-tile ROM address. All timing signals are delayed by the
// same two cycles so that they stay aligned with the select outputs.
//
// Ports
//   i_pclk, i_rst_n        pixel clock, asynchronous active-low reset
//   i_hcount, i_vcount     current pixel position (11 bits each)
//   i_hsync, i_vsync       sync inputs
//   i_hblnk, i_vblnk       blanking inputs
//   o_map_addr             map RAM address (row*MAP_COLS+col), 0 outside map
//   i_map_data             map RAM data, valid the cycle after o_map_addr
//   i_plr{1,2}_en/_x/_y    player visibility and top-left position
//   o_sel                  0 path, 1 obs1, 2 obs2, 3 bomb, 4 expl, 5 plr1, 6 plr2
//   o_rom_addr             {row offset, col offset} inside tile or sprite
//   o_in_area              pixel inside the map and not blanked
//   o_hcount .. o_vblnk    timing inputs delayed by two cycles
//
// Map RAM contract: o_map_addr is registered at the stage-1 edge. The RAM
// must present the matching word on i_map_data before the next edge, where
// stage 2 samples it. There is no handshake; the RAM is assumed to always
// answer within that one cycle.
// -----------------------------------------------------------------------------
module tile_sel_gen #(
  parameter int TILE_BITS = 5,
  parameter int MAP_COLS  = 32,
  parameter int MAP_ROWS  = 24
) (
  input  logic        i_pclk,
  input  logic        i_rst_n,
  input  logic [10:0] i_hcount,
  input  logic [10:0] i_vcount,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_hblnk,
  input  logic        i_vblnk,
  output logic [9:0]  o_map_addr,
  input  logic [2:0]  i_map_data,
  input  logic        i_plr1_en,
  input  logic [10:0] i_plr1_x,
  input  logic [10:0] i_plr1_y,
  input  logic        i_plr2_en,
  input  logic [10:0] i_plr2_x,
  input  logic [10:0] i_plr2_y,
  output logic [2:0]  o_sel,
  output logic [9:0]  o_rom_addr,
  output logic        o_in_area,
  output logic [10:0] o_hcount,
  output logic [10:0] o_vcount,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hblnk,
  output logic        o_vblnk
);

  localparam int TW  = TILE_BITS;
  localparam int CW  = 11 - TILE_BITS;   // width of tile column/row index
  localparam int SPR = 1 << TILE_BITS;   // sprite edge equals tile edge

  localparam logic [2:0] SEL_PATH = 3'd0;
  localparam logic [2:0] SEL_EXPL = 3'd4;
  localparam logic [2:0] SEL_PLR1 = 3'd5;
  localparam logic [2:0] SEL_PLR2 = 3'd6;

  // ---------------------------------------------------------------------------
  // Player position latch. Shadow registers are loaded only on the rising
  // edge of vblank, so a whole frame is drawn with one consistent set of
  // positions. The compare in stage 1 reads the shadow registers as they
  // were before the edge, so the latch affects only later pixels.
  // ---------------------------------------------------------------------------
  logic        vblnk_q;
  logic        lat1_en;
  logic [10:0] lat1_x;
  logic [10:0] lat1_y;
  logic        lat2_en;
  logic [10:0] lat2_x;
  logic [10:0] lat2_y;
  logic        vblnk_rise;

  assign vblnk_rise = i_vblnk & ~vblnk_q;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      vblnk_q <= 1'b0;
      lat1_en <= 1'b0;
      lat1_x  <= '0;
      lat1_y  <= '0;
      lat2_en <= 1'b0;
      lat2_x  <= '0;
      lat2_y  <= '0;
    end else begin
      vblnk_q <= i_vblnk;
      if (vblnk_rise) begin
        lat1_en <= i_plr1_en;
        lat1_x  <= i_plr1_x;
        lat1_y  <= i_plr1_y;
        lat2_en <= i_plr2_en;
        lat2_x  <= i_plr2_x;
        lat2_y  <= i_plr2_y;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1 combinational: map address, area flag, and sprite hit tests.
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic          in_map;
  logic [9:0]    map_addr_d;
  logic          in_area_d;

  assign col    = i_hcount[10:TW];
  assign row    = i_vcount[10:TW];
  assign in_map = (col < CW'(MAP_COLS)) && (row < CW'(MAP_ROWS));

  always_comb begin
    map_addr_d = '0;
    if (in_map) begin
      map_addr_d = 10'(row) * 10'(MAP_COLS) + 10'(col);
    end
  end

  assign in_area_d = in_map & ~i_hblnk & ~i_vblnk;

  // The box compare is widened to 12 bits so that x + SPR cannot wrap
  // near the top of the 11-bit range; a sprite at x=2040 must not hit h=0.
  function automatic logic box_hit(input logic        en,
                                   input logic [10:0] x,
                                   input logic [10:0] y,
                                   input logic [10:0] h,
                                   input logic [10:0] v);
    logic [11:0] hx;
    logic [11:0] vx;
    logic [11:0] xx;
    logic [11:0] yx;
    hx = {1'b0, h};
    vx = {1'b0, v};
    xx = {1'b0, x};
    yx = {1'b0, y};
    box_hit = en && (hx >= xx) && (hx < xx + 12'(SPR)) &&
                    (vx >= yx) && (vx < yx + 12'(SPR));
  endfunction

  logic          p1_hit_d;
  logic          p2_hit_d;
  logic [TW-1:0] p1_hoff_d;
  logic [TW-1:0] p1_voff_d;
  logic [TW-1:0] p2_hoff_d;
  logic [TW-1:0] p2_voff_d;

  assign p1_hit_d = box_hit(lat1_en, lat1_x, lat1_y, i_hcount, i_vcount);
  assign p2_hit_d = box_hit(lat2_en, lat2_x, lat2_y, i_hcount, i_vcount);

  // Low bits of a difference depend only on the low bits of the operands,
  // so the sprite offset is formed directly in TILE_BITS width.
  assign p1_hoff_d = i_hcount[TW-1:0] - lat1_x[TW-1:0];
  assign p1_voff_d = i_vcount[TW-1:0] - lat1_y[TW-1:0];
  assign p2_hoff_d = i_hcount[TW-1:0] - lat2_x[TW-1:0];
  assign p2_voff_d = i_vcount[TW-1:0] - lat2_y[TW-1:0];

  // ---------------------------------------------------------------------------
  // Stage 1 registers.
  // ---------------------------------------------------------------------------
  logic          s1_in_area;
  logic [TW-1:0] s1_hoff;
  logic [TW-1:0] s1_voff;
  logic          s1_p1_hit;
  logic          s1_p2_hit;
  logic [TW-1:0] s1_p1_hoff;
  logic [TW-1:0] s1_p1_voff;
  logic [TW-1:0] s1_p2_hoff;
  logic [TW-1:0] s1_p2_voff;
  logic [10:0]   s1_hcount;
  logic [10:0]   s1_vcount;
  logic          s1_hsync;
  logic          s1_vsync;
  logic          s1_hblnk;
  logic          s1_vblnk;

  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_map_addr <= '0;
      s1_in_area <= 1'b0;
      s1_hoff    <= '0;
      s1_voff    <= '0;
      s1_p1_hit  <= 1'b0;
      s1_p2_hit  <= 1'b0;
      s1_p1_hoff <= '0;
      s1_p1_voff <= '0;
      s1_p2_hoff <= '0;
      s1_p2_voff <= '0;
      s1_hcount  <= '0;
      s1_vcount  <= '0;
      s1_hsync   <= 1'b0;
      s1_vsync   <= 1'b0;
      s1_hblnk   <= 1'b0;
      s1_vblnk   <= 1'b0;
    end else begin
      o_map_addr <= map_addr_d;
      s1_in_area <= in_area_d;
      s1_hoff    <= i_hcount[TW-1:0];
      s1_voff    <= i_vcount[TW-1:0];
      s1_p1_hit  <= p1_hit_d;
      s1_p2_hit  <= p2_hit_d;
      s1_p1_hoff <= p1_hoff_d;
      s1_p1_voff <= p1_voff_d;
      s1_p2_hoff <= p2_hoff_d;
      s1_p2_voff <= p2_voff_d;
      s1_hcount  <= i_hcount;
      s1_vcount  <= i_vcount;
      s1_hsync   <= i_hsync;
      s1_vsync   <= i_vsync;
      s1_hblnk   <= i_hblnk;
      s1_vblnk   <= i_vblnk;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 combinational: priority merge of area, sprites and map code.
  // Player 1 sits above player 2, which sits above the map. Map codes above
  // the explosion code are unused and are drawn as path.
  // ---------------------------------------------------------------------------
  logic [2:0] sel_d;
  logic [9:0] rom_addr_d;

  always_comb begin
    sel_d      = SEL_PATH;
    rom_addr_d = '0;
    if (s1_in_area) begin
      if (s1_p1_hit) begin
        sel_d      = SEL_PLR1;
        rom_addr_d = 10'({s1_p1_voff, s1_p1_hoff});
      end else if (s1_p2_hit) begin
        sel_d      = SEL_PLR2;
        rom_addr_d = 10'({s1_p2_voff, s1_p2_hoff});
      end else begin
        sel_d      = (i_map_data > SEL_EXPL) ? SEL_PATH : i_map_data;
        rom_addr_d = 10'({s1_voff, s1_hoff});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2 registers (block outputs).
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_pclk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_sel      <= '0;
      o_rom_addr <= '0;
      o_in_area  <= 1'b0;
      o_hcount   <= '0;
      o_vcount   <= '0;
      o_hsync    <= 1'b0;
      o_vsync    <= 1'b0;
      o_hblnk    <= 1'b0;
      o_vblnk    <= 1'b0;
    end else begin
      o_sel      <= sel_d;
      o_rom_addr <= rom_addr_d;
      o_in_area  <= s1_in_area;
      o_hcount   <= s1_hcount;
      o_vcount   <= s1_vcount;
      o_hsync    <= s1_hsync;
      o_vsync    <= s1_vsync;
      o_hblnk    <= s1_hblnk;
      o_vblnk    <= s1_vblnk;
    end
  end

endmodule
